// File: rtl/rs_station_param_pkg.sv
// Shared types for the parametrised reservation station.
package rs_station_param_pkg;

    // Per-entry lifecycle: FREE -> WAIT (dispatched) -> EXEC (issued) -> FREE (own tag broadcast)
    typedef enum logic [1:0] {
        ST_FREE = 2'd0,
        ST_WAIT = 2'd1,
        ST_EXEC = 2'd2
    } entry_state_t;

    // Tag value meaning "operand already valid, no producer"
    localparam int unsigned NO_LABEL = 0;

endpackage

// File: rtl/rs_station_param_if.sv
// Dispatch, CDB and issue signals between CU/FU (master) and the station (slave).
interface rs_station_param_if #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned LABEL_W = 4,
    parameter int unsigned OP_W    = 2
);
    logic                         disp_valid;
    logic [OP_W-1:0]              disp_op;
    logic [DATA_W-1:0]            disp_vj;
    logic [LABEL_W-1:0]           disp_qj;
    logic [DATA_W-1:0]            disp_vk;
    logic [LABEL_W-1:0]           disp_qk;
    logic                         disp_ready;
    logic [LABEL_W-1:0]           disp_label;

    logic                         bc_en;
    logic [LABEL_W-1:0]           bc_label;
    logic [DATA_W-1:0]            bc_data;

    logic                         iss_valid;
    logic                         iss_accept;
    logic [OP_W-1:0]              iss_op;
    logic [DATA_W-1:0]            iss_a;
    logic [DATA_W-1:0]            iss_b;
    logic [LABEL_W-1:0]           iss_label;

    logic [$clog2(DEPTH+1)-1:0]   count;

    modport master (
        output disp_valid, disp_op, disp_vj, disp_qj, disp_vk, disp_qk,
        output bc_en, bc_label, bc_data, iss_accept,
        input  disp_ready, disp_label, iss_valid, iss_op, iss_a, iss_b, iss_label, count
    );

    modport slave (
        input  disp_valid, disp_op, disp_vj, disp_qj, disp_vk, disp_qk,
        input  bc_en, bc_label, bc_data, iss_accept,
        output disp_ready, disp_label, iss_valid, iss_op, iss_a, iss_b, iss_label, count
    );

endinterface

// File: rtl/rs_station_param_age_picker.sv
// Age matrix and oldest-ready one-hot selector for the reservation station.
module rs_age_picker #(
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [DEPTH-1:0] alloc,
    input  logic [DEPTH-1:0] occupied,
    input  logic [DEPTH-1:0] ready,
    input  logic             accept,
    output logic [DEPTH-1:0] grant
);
    // age[i][j] = 1 means entry j is older than entry i
    logic [DEPTH-1:0] age [DEPTH];
    logic [DEPTH-1:0] pick;
    logic             lock_q;
    logic [DEPTH-1:0] lock_grant_q;

    // New entry is younger than everything occupied; its column is cleared in all other rows
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (clr) begin
                age[i] <= '0;
            end else if (alloc[i]) begin
                age[i] <= occupied;
            end else begin
                age[i] <= age[i] & ~alloc;
            end
        end
    end

    // Oldest ready entry: ready with no ready entry older than itself
    always_comb begin
        pick = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            pick[i] = ready[i] && ((age[i] & ready) == '0);
        end
    end

    // A presented but unaccepted op stays selected so the issue bus holds steady
    always_ff @(posedge clk) begin
        if (clr) begin
            lock_q       <= 1'b0;
            lock_grant_q <= '0;
        end else begin
            lock_q       <= (|grant) && !accept;
            lock_grant_q <= grant;
        end
    end

    // Final grant: held selection while locked, otherwise the oldest ready entry
    always_comb begin
        grant = lock_q ? (lock_grant_q & ready) : pick;
    end

endmodule

// File: rtl/rs_station_param.sv
// Reservation station: DEPTH entries, CDB snoop and bypass, oldest-ready issue to one FU.
module rs_station_param
    import rs_station_param_pkg::*;
#(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned LABEL_W    = 4,
    parameter int unsigned OP_W       = 2,
    parameter int unsigned LABEL_BASE = 1
) (
    input  logic              clk,
    input  logic              nRST,
    input  logic              flush,
    rs_station_param_if.slave bus
);
    localparam int unsigned       IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned       CNT_W = $clog2(DEPTH + 1);
    localparam logic [LABEL_W-1:0] NONE = LABEL_W'(NO_LABEL);

    entry_state_t        state_q [DEPTH];
    entry_state_t        state_d [DEPTH];
    logic [OP_W-1:0]     op_q    [DEPTH];
    logic [OP_W-1:0]     op_d    [DEPTH];
    logic [DATA_W-1:0]   vj_q    [DEPTH];
    logic [DATA_W-1:0]   vj_d    [DEPTH];
    logic [DATA_W-1:0]   vk_q    [DEPTH];
    logic [DATA_W-1:0]   vk_d    [DEPTH];
    logic [LABEL_W-1:0]  qj_q    [DEPTH];
    logic [LABEL_W-1:0]  qj_d    [DEPTH];
    logic [LABEL_W-1:0]  qk_q    [DEPTH];
    logic [LABEL_W-1:0]  qk_d    [DEPTH];

    logic                clr;
    logic                disp_fire;
    logic                free_found;
    logic [IDX_W-1:0]    free_idx;
    logic [DEPTH-1:0]    first_free;
    logic [DEPTH-1:0]    alloc_vec;
    logic [DEPTH-1:0]    occ_vec;
    logic [DEPTH-1:0]    ready_vec;
    logic [DEPTH-1:0]    grant;
    logic [CNT_W-1:0]    occ_cnt;

    assign clr = nRST | flush;

    // Occupancy/readiness vectors and the lowest-index free entry
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        first_free = '0;
        occ_vec    = '0;
        ready_vec  = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            occ_vec[i]   = (state_q[i] != ST_FREE);
            ready_vec[i] = (state_q[i] == ST_WAIT) && (qj_q[i] == NONE) && (qk_q[i] == NONE);
            if ((state_q[i] == ST_FREE) && !free_found) begin
                free_found    = 1'b1;
                free_idx      = IDX_W'(i);
                first_free[i] = 1'b1;
            end
        end
    end

    assign disp_fire      = bus.disp_valid & free_found;
    assign alloc_vec      = disp_fire ? first_free : '0;
    assign bus.disp_ready = free_found;
    assign bus.disp_label = LABEL_W'(LABEL_BASE) + LABEL_W'(free_idx);

    rs_age_picker #(
        .DEPTH(DEPTH)
    ) u_age (
        .clk      (clk),
        .clr      (clr),
        .alloc    (alloc_vec),
        .occupied (occ_vec),
        .ready    (ready_vec),
        .accept   (bus.iss_accept),
        .grant    (grant)
    );

    // Per-entry next state: dispatch with CDB bypass, operand snoop, issue, release
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            state_d[i] = state_q[i];
            op_d[i]    = op_q[i];
            vj_d[i]    = vj_q[i];
            vk_d[i]    = vk_q[i];
            qj_d[i]    = qj_q[i];
            qk_d[i]    = qk_q[i];
            case (state_q[i])
                ST_WAIT: begin
                    if (bus.bc_en && (qj_q[i] != NONE) && (qj_q[i] == bus.bc_label)) begin
                        vj_d[i] = bus.bc_data;
                        qj_d[i] = NONE;
                    end
                    if (bus.bc_en && (qk_q[i] != NONE) && (qk_q[i] == bus.bc_label)) begin
                        vk_d[i] = bus.bc_data;
                        qk_d[i] = NONE;
                    end
                    if (grant[i] && bus.iss_accept) begin
                        state_d[i] = ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (bus.bc_en && (bus.bc_label == LABEL_W'(LABEL_BASE + i))) begin
                        state_d[i] = ST_FREE;
                    end
                end
                default: begin
                    if (alloc_vec[i]) begin
                        state_d[i] = ST_WAIT;
                        op_d[i]    = bus.disp_op;
                        if (bus.bc_en && (bus.disp_qj != NONE) && (bus.disp_qj == bus.bc_label)) begin
                            vj_d[i] = bus.bc_data;
                            qj_d[i] = NONE;
                        end else begin
                            vj_d[i] = bus.disp_vj;
                            qj_d[i] = bus.disp_qj;
                        end
                        if (bus.bc_en && (bus.disp_qk != NONE) && (bus.disp_qk == bus.bc_label)) begin
                            vk_d[i] = bus.bc_data;
                            qk_d[i] = NONE;
                        end else begin
                            vk_d[i] = bus.disp_vk;
                            qk_d[i] = bus.disp_qk;
                        end
                    end
                end
            endcase
        end
    end

    // Entry state register; reset and flush free every entry
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            state_q[i] <= clr ? ST_FREE : state_d[i];
        end
    end

    // Entry payload register; only meaningful while the entry is not FREE
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            op_q[i] <= op_d[i];
            vj_q[i] <= vj_d[i];
            vk_q[i] <= vk_d[i];
            qj_q[i] <= clr ? NONE : qj_d[i];
            qk_q[i] <= clr ? NONE : qk_d[i];
        end
    end

    // Issue bus driven from the granted entry, zero when nothing is ready
    always_comb begin
        bus.iss_valid = |grant;
        bus.iss_op    = '0;
        bus.iss_a     = '0;
        bus.iss_b     = '0;
        bus.iss_label = NONE;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (grant[i]) begin
                bus.iss_op    = op_q[i];
                bus.iss_a     = vj_q[i];
                bus.iss_b     = vk_q[i];
                bus.iss_label = LABEL_W'(LABEL_BASE + i);
            end
        end
    end

    // Occupied-entry count
    always_comb begin
        occ_cnt = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            occ_cnt = occ_cnt + CNT_W'(occ_vec[i]);
        end
    end

    assign bus.count = occ_cnt;

endmodule

// File: tb/tb_rs_station_param.sv
// Directed bench for rs_station_param: issue scoreboard plus status checks.
module tb_rs_station_param;

    logic clk;
    logic nRST;
    logic flush;

    rs_station_param_if #(.DEPTH(4), .DATA_W(32), .LABEL_W(4), .OP_W(2)) bus ();

    rs_station_param #(
        .DEPTH(4), .DATA_W(32), .LABEL_W(4), .OP_W(2), .LABEL_BASE(1)
    ) dut (
        .clk   (clk),
        .nRST  (nRST),
        .flush (flush),
        .bus   (bus)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  label;
    } exp_t;

    exp_t exp_q [$];
    exp_t mon_e;
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every accepted issue is matched against the next expected op
    always @(negedge clk) begin
        if (bus.iss_valid === 1'b1 && bus.iss_accept === 1'b1) begin
            total_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_issue: got label %0d op %0d a 0x%0h b 0x%0h, expected no issue",
                         bus.iss_label, bus.iss_op, bus.iss_a, bus.iss_b);
            end else begin
                mon_e = exp_q.pop_front();
                if (bus.iss_op === mon_e.op && bus.iss_a === mon_e.a &&
                    bus.iss_b === mon_e.b && bus.iss_label === mon_e.label) begin
                    pass_cnt++;
                end else begin
                    $display("FAIL issue: got label %0d op %0d a 0x%0h b 0x%0h, expected label %0d op %0d a 0x%0h b 0x%0h",
                             bus.iss_label, bus.iss_op, bus.iss_a, bus.iss_b,
                             mon_e.label, mon_e.op, mon_e.a, mon_e.b);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic push(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [3:0] label);
        exp_t e;
        e.op = op; e.a = a; e.b = b; e.label = label;
        exp_q.push_back(e);
    endtask

    task automatic dispatch(input logic [1:0] op, input logic [31:0] vj, input logic [3:0] qj,
                            input logic [31:0] vk, input logic [3:0] qk, input logic [3:0] exp_label);
        check("disp_label", 32'(bus.disp_label), 32'(exp_label));
        bus.disp_valid = 1'b1;
        bus.disp_op    = op;
        bus.disp_vj    = vj;
        bus.disp_qj    = qj;
        bus.disp_vk    = vk;
        bus.disp_qk    = qk;
        step();
        bus.disp_valid = 1'b0;
    endtask

    task automatic bcast(input logic [3:0] label, input logic [31:0] data);
        bus.bc_en    = 1'b1;
        bus.bc_label = label;
        bus.bc_data  = data;
        step();
        bus.bc_en    = 1'b0;
    endtask

    initial begin
        nRST = 1'b1;
        flush = 1'b0;
        bus.disp_valid = 1'b0; bus.disp_op = '0; bus.disp_vj = '0; bus.disp_qj = '0;
        bus.disp_vk = '0; bus.disp_qk = '0;
        bus.bc_en = 1'b0; bus.bc_label = '0; bus.bc_data = '0;
        bus.iss_accept = 1'b0;

        // Reset state
        step(); step();
        check("rst_disp_ready", 32'(bus.disp_ready), 32'd1);
        check("rst_iss_valid",  32'(bus.iss_valid),  32'd0);
        check("rst_count",      32'(bus.count),      32'd0);
        check("rst_iss_a",      bus.iss_a,           32'd0);
        nRST = 1'b0;
        step();

        // Fill: four ready ops, labels 1..4, then a refused dispatch
        dispatch(2'd0, 32'h11, 4'd0, 32'h21, 4'd0, 4'd1); push(2'd0, 32'h11, 32'h21, 4'd1);
        dispatch(2'd1, 32'h12, 4'd0, 32'h22, 4'd0, 4'd2); push(2'd1, 32'h12, 32'h22, 4'd2);
        dispatch(2'd2, 32'h13, 4'd0, 32'h23, 4'd0, 4'd3); push(2'd2, 32'h13, 32'h23, 4'd3);
        dispatch(2'd3, 32'h14, 4'd0, 32'h24, 4'd0, 4'd4); push(2'd3, 32'h14, 32'h24, 4'd4);
        check("full_count",      32'(bus.count),      32'd4);
        check("full_disp_ready", 32'(bus.disp_ready), 32'd0);
        bus.disp_valid = 1'b1; bus.disp_op = 2'd3; bus.disp_vj = 32'hEE; bus.disp_qj = '0;
        step();
        bus.disp_valid = 1'b0;
        check("full_ignored_count", 32'(bus.count), 32'd4);
        bus.iss_accept = 1'b1;
        repeat (4) step();
        check("fill_drained_iss_valid", 32'(bus.iss_valid), 32'd0);
        check("exec_count", 32'(bus.count), 32'd4);

        // Release label 2; its slot becomes the next allocation
        check("bc_cycle_disp_ready", 32'(bus.disp_ready), 32'd0);
        bcast(4'd2, 32'h1234);
        check("rel_count",      32'(bus.count),      32'd3);
        check("rel_disp_ready", 32'(bus.disp_ready), 32'd1);
        dispatch(2'd1, 32'h66, 4'd0, 32'h77, 4'd0, 4'd2); push(2'd1, 32'h66, 32'h77, 4'd2);
        step();
        bcast(4'd1, 32'h0); bcast(4'd3, 32'h0); bcast(4'd4, 32'h0); bcast(4'd2, 32'h0);
        check("rel_all_count", 32'(bus.count), 32'd0);

        // Wakeup through CDB; own-tag broadcast of a WAIT entry is ignored
        dispatch(2'd2, 32'h0, 4'd5, 32'h7, 4'd0, 4'd1);
        check("wait_iss_valid", 32'(bus.iss_valid), 32'd0);
        bcast(4'd1, 32'h99);
        check("own_tag_wait_count", 32'(bus.count), 32'd1);
        check("own_tag_wait_valid", 32'(bus.iss_valid), 32'd0);
        push(2'd2, 32'h10, 32'h7, 4'd1);
        bcast(4'd5, 32'h10);
        check("wake_iss_valid", 32'(bus.iss_valid), 32'd1);
        step();
        bcast(4'd1, 32'h0);

        // Bypass: broadcast in the dispatch cycle fills operand B
        bus.bc_en = 1'b1; bus.bc_label = 4'd6; bus.bc_data = 32'hAB;
        dispatch(2'd3, 32'h5, 4'd0, 32'h0, 4'd6, 4'd1);
        bus.bc_en = 1'b0;
        push(2'd3, 32'h5, 32'hAB, 4'd1);
        check("bypass_iss_valid", 32'(bus.iss_valid), 32'd1);
        step();
        bcast(4'd1, 32'h0);

        // Age and hold: younger ready op is presented and held, then the woken elder follows
        bus.iss_accept = 1'b0;
        dispatch(2'd0, 32'h0, 4'd5, 32'h22, 4'd0, 4'd1);
        dispatch(2'd1, 32'h33, 4'd0, 32'h44, 4'd0, 4'd2);
        check("age_first_label", 32'(bus.iss_label), 32'd2);
        step();
        check("hold_label", 32'(bus.iss_label), 32'd2);
        check("hold_a",     bus.iss_a,          32'h33);
        bcast(4'd5, 32'h55);
        check("hold_after_wake_label", 32'(bus.iss_label), 32'd2);
        check("hold_after_wake_b",     bus.iss_b,          32'h44);
        push(2'd1, 32'h33, 32'h44, 4'd2);
        push(2'd0, 32'h55, 32'h22, 4'd1);
        bus.iss_accept = 1'b1;
        step(); step();
        check("age_done_iss_valid", 32'(bus.iss_valid), 32'd0);
        bcast(4'd1, 32'h0); bcast(4'd2, 32'h0);
        check("age_rel_count", 32'(bus.count), 32'd0);

        // Flush with WAIT/EXEC entries; flush beats same-cycle dispatch and release
        push(2'd1, 32'hA1, 32'hA2, 4'd1);
        dispatch(2'd1, 32'hA1, 4'd0, 32'hA2, 4'd0, 4'd1);
        dispatch(2'd2, 32'h0, 4'd5, 32'hB2, 4'd0, 4'd2);
        dispatch(2'd3, 32'hC1, 4'd0, 32'h0, 4'd6, 4'd3);
        check("pre_flush_count", 32'(bus.count), 32'd3);
        flush = 1'b1;
        bus.disp_valid = 1'b1; bus.disp_qj = '0; bus.disp_qk = '0;
        bus.bc_en = 1'b1; bus.bc_label = 4'd1; bus.bc_data = 32'h0;
        step();
        flush = 1'b0; bus.disp_valid = 1'b0; bus.bc_en = 1'b0;
        check("flush_count",      32'(bus.count),      32'd0);
        check("flush_iss_valid",  32'(bus.iss_valid),  32'd0);
        check("flush_disp_ready", 32'(bus.disp_ready), 32'd1);
        check("flush_disp_label", 32'(bus.disp_label), 32'd1);
        bcast(4'd1, 32'hDEAD);
        bcast(4'd5, 32'hBEEF);
        check("stale_bc_count",     32'(bus.count),     32'd0);
        check("stale_bc_iss_valid", 32'(bus.iss_valid), 32'd0);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
